writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  MEM/WB pipeline register plus write-back select for the MIPS datapath; sits directly upstream of
//  the register file and drives its Reg_Write_i, Write_Register_i and Write_Data_i inputs.
//  Captures MEM-stage results, aligns/extends load data, resolves JAL link writes and masks writes
//  to r0. Also exports the WB destination and data for the forwarding unit.
// PARAMETERS
//  WIDTH    32   datapath width (ALU result, memory word, PC+4, write data)
//  REG_AW   5    register index width
// PORTS
//  clk                 in   1       rising-edge clock
//  rst_n               in   1       synchronous reset, active-low
//  Stall_i             in   1       hold stage contents (no capture)
//  Flush_i             in   1       insert bubble on next edge
//  Valid_i             in   1       MEM stage holds a real instruction
//  Reg_Write_i         in   1       instruction writes a register
//  MemtoReg_i          in   1       write data comes from load data
//  Jal_i               in   1       link write: data = PC+4, dest = r31
//  Load_Size_i         in   2       00 word, 01 byte, 10 half, 11 reserved (treated as word)
//  Load_Unsigned_i     in   1       zero-extend byte/half when 1, sign-extend when 0
//  Write_Register_i    in   REG_AW  destination index from MEM
//  ALU_Result_i        in   WIDTH   ALU result; bits [1:0] are the load byte offset
//  Mem_Data_i          in   WIDTH   raw word read from data memory
//  PC_Plus4_i          in   WIDTH   return address for JAL
//  Reg_Write_o         out  1       to register file write enable
//  Write_Register_o    out  REG_AW  to register file write index
//  Write_Data_o        out  WIDTH   to register file write data
//  Wb_Valid_o          out  1       stage holds a real instruction
//  Misaligned_o        out  1       captured load was misaligned for its size
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all stored fields cleared; every output 0. Takes priority over all.
//  - Capture: one register stage, latency 1 cycle; outputs are pure functions of stored fields.
//  - Priority at each edge: reset > Flush_i > Stall_i > capture.
//    Flush_i=1: valid cleared, data fields don't-care (outputs must still show Reg_Write_o=0).
//    Flush_i=1 with Stall_i=1: flush wins. Stall_i=1: all stored fields hold their value.
//  - Dest: Jal_i ? 5'd31 : Write_Register_i (resolved before capture).
//  - Reg_Write_o = valid & regwrite & (dest != 0). Writes to r0 never reach the file.
//  - Write_Data_o select: Jal -> PC+4; else MemtoReg -> aligned load; else ALU result.
//    Jal overrides MemtoReg if both set.
//  - Load alignment (little-endian, offset = ALU_Result_i[1:0] captured with the op):
//    byte: lane = offset, bits [8*off+7 : 8*off], extended per Load_Unsigned_i.
//    half: lane = offset[1] ([15:0] or [31:16]); offset[0]=1 -> Misaligned_o=1, data from offset[1] lane.
//    word: full word; offset!=0 -> Misaligned_o=1, data unchanged.
//  - Misaligned_o only when valid & MemtoReg & ~Jal; write is NOT suppressed (trap handled elsewhere).
//  - Wb_Valid_o = stored valid; Valid_i=0 captures a bubble (Reg_Write_o=0) regardless of other inputs.
//  - Mid-operation reset: next cycle shows a bubble, no residual write.
// STRUCTURE
//  - Shared package wb_pkg: LOAD_WORD/LOAD_BYTE/LOAD_HALF encodings, LINK_REG=5'd31, REG_ZERO=5'd0.
//  - Sub-module load_align (combinational): raw word, offset, size, unsigned -> aligned data, misaligned.
//    Placed after the register so captured raw fields feed it; the top holds register + select only.
// TESTING
//  1. rst_n=0 for 2 cycles with all inputs active -> all outputs 0; release -> first capture after 1 edge.
//  2. ALU op: Valid=1,RegWrite=1,Write_Register=8,ALU=0x0000_1234 -> next cycle Reg_Write_o=1, idx 8, data 0x1234.
//  3. lb signed, Mem=0x80FF_7F01, off=3 -> 0xFFFF_FF80; lbu off=3 -> 0x0000_0080; lh off=2 -> 0xFFFF_80FF;
//     lh off=1 -> Misaligned_o=1.
//  4. JAL with Write_Register=5, PC+4=0x0040_0010, MemtoReg=1 -> idx 31, data 0x0040_0010, Misaligned_o=0.
//  5. Write to r0 with RegWrite=1 -> Reg_Write_o=0; Valid_i=0 with RegWrite=1 -> Reg_Write_o=0.
//  6. Stall 3 cycles while inputs change -> outputs frozen; Stall+Flush same edge -> bubble next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the MEM/WB write-back stage: load-size encodings and
// the architecturally special register indices.
package wb_pkg;

    localparam logic [1:0] LOAD_WORD = 2'b00;
    localparam logic [1:0] LOAD_BYTE = 2'b01;
    localparam logic [1:0] LOAD_HALF = 2'b10;
    localparam logic [1:0] LOAD_RSVD = 2'b11;

    localparam logic [4:0] LINK_REG = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Combinational little-endian load aligner: picks the byte/half lane from the
// raw memory word, extends it, and flags offsets illegal for the access size.
module load_align
    import wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] raw_i,
    input  logic [1:0]       offset_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    output logic [WIDTH-1:0] data_o,
    output logic             misaligned_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        byte_sign_s;
    logic        half_sign_s;

    // Lane extraction, extension and alignment check
    always_comb begin
        byte_s       = raw_i[{offset_i, 3'b000} +: 8];
        half_s       = offset_i[1] ? raw_i[16 +: 16] : raw_i[0 +: 16];
        byte_sign_s  = byte_s[7] & ~unsigned_i;
        half_sign_s  = half_s[15] & ~unsigned_i;
        data_o       = raw_i;
        misaligned_o = 1'b0;
        case (size_i)
            LOAD_BYTE: begin
                data_o       = {{(WIDTH-8){byte_sign_s}}, byte_s};
                misaligned_o = 1'b0;
            end
            LOAD_HALF: begin
                // An odd half offset still returns the offset[1] lane; the trap is raised elsewhere
                data_o       = {{(WIDTH-16){half_sign_s}}, half_s};
                misaligned_o = offset_i[0];
            end
            default: begin
                // Word and the reserved encoding both behave as a full-word load
                data_o       = raw_i;
                misaligned_o = (offset_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back select feeding the register file
// and the forwarding unit. Outputs are functions of the stored fields only.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall_i,
    input  logic              Flush_i,
    input  logic              Valid_i,
    input  logic              Reg_Write_i,
    input  logic              MemtoReg_i,
    input  logic              Jal_i,
    input  logic [1:0]        Load_Size_i,
    input  logic              Load_Unsigned_i,
    input  logic [REG_AW-1:0] Write_Register_i,
    input  logic [WIDTH-1:0]  ALU_Result_i,
    input  logic [WIDTH-1:0]  Mem_Data_i,
    input  logic [WIDTH-1:0]  PC_Plus4_i,
    output logic              Reg_Write_o,
    output logic [REG_AW-1:0] Write_Register_o,
    output logic [WIDTH-1:0]  Write_Data_o,
    output logic              Wb_Valid_o,
    output logic              Misaligned_o
);

    logic              valid_q,    valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              jal_q,      jal_d;
    logic [1:0]        size_q,     size_d;
    logic              unsigned_q, unsigned_d;
    logic [REG_AW-1:0] dest_q,     dest_d;
    logic [WIDTH-1:0]  alu_q,      alu_d;
    logic [WIDTH-1:0]  mem_q,      mem_d;
    logic [WIDTH-1:0]  pc4_q,      pc4_d;

    logic [WIDTH-1:0]  load_data_s;
    logic              load_mis_s;

    // Next-state: flush beats stall beats capture; the link destination is resolved here
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        jal_d      = jal_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        dest_d     = dest_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        pc4_d      = pc4_q;
        if (Flush_i) begin
            valid_d = 1'b0;
        end else if (Stall_i) begin
            valid_d = valid_q;
        end else begin
            valid_d    = Valid_i;
            regwrite_d = Reg_Write_i;
            memtoreg_d = MemtoReg_i;
            jal_d      = Jal_i;
            size_d     = Load_Size_i;
            unsigned_d = Load_Unsigned_i;
            dest_d     = Jal_i ? LINK_REG : Write_Register_i;
            alu_d      = ALU_Result_i;
            mem_d      = Mem_Data_i;
            pc4_d      = PC_Plus4_i;
        end
    end

    // Stage register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            jal_q      <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            dest_q     <= '0;
            alu_q      <= '0;
            mem_q      <= '0;
            pc4_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            jal_q      <= jal_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            dest_q     <= dest_d;
            alu_q      <= alu_d;
            mem_q      <= mem_d;
            pc4_q      <= pc4_d;
        end
    end

    load_align #(.WIDTH(WIDTH)) u_load_align (
        .raw_i        (mem_q),
        .offset_i     (alu_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .data_o       (load_data_s),
        .misaligned_o (load_mis_s)
    );

    // Write-back select and r0 masking
    always_comb begin
        Reg_Write_o      = valid_q & regwrite_q & (dest_q != REG_ZERO);
        Write_Register_o = dest_q;
        Wb_Valid_o       = valid_q;
        Misaligned_o     = valid_q & memtoreg_q & ~jal_q & load_mis_s;
        if (jal_q) begin
            Write_Data_o = pc4_q;
        end else if (memtoreg_q) begin
            Write_Data_o = load_data_s;
        end else begin
            Write_Data_o = alu_q;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a transaction-level model of
// the write-back rules, with directed cases for loads, JAL, r0 and stalls.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, valid, regwrite, memtoreg, jal, uns;
    logic [1:0]  size;
    logic [4:0]  wreg;
    logic [31:0] alu, mem, pc4;
    logic        rw_o, wbv_o, mis_o;
    logic [4:0]  idx_o;
    logic [31:0] data_o;

    int n_cmp = 0;
    int n_err = 0;

    // Expected visible state of the stage
    logic        m_valid, m_rw, m_mis, m_chk;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .Stall_i(stall), .Flush_i(flush), .Valid_i(valid),
        .Reg_Write_i(regwrite), .MemtoReg_i(memtoreg), .Jal_i(jal), .Load_Size_i(size),
        .Load_Unsigned_i(uns), .Write_Register_i(wreg), .ALU_Result_i(alu),
        .Mem_Data_i(mem), .PC_Plus4_i(pc4), .Reg_Write_o(rw_o), .Write_Register_o(idx_o),
        .Write_Data_o(data_o), .Wb_Valid_o(wbv_o), .Misaligned_o(mis_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int sz, input logic u);
        logic [31:0] v;
        if (sz == 1) begin
            v = (w >> (8 * off)) & 32'h0000_00FF;
            if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
            if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic ref_mis(input int off, input int sz);
        if (sz == 1) return 1'b0;
        if (sz == 2) return (off % 2) != 0;
        return off != 0;
    endfunction

    task automatic model_edge();
        int          off;
        logic [4:0]  dest;
        if (!rst_n) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mis = 1'b0; m_idx = 5'd0; m_data = 32'd0; m_chk = 1'b1;
        end else if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mis = 1'b0; m_chk = 1'b0;
        end else if (!stall) begin
            off     = int'(alu % 32'd4);
            dest    = jal ? 5'd31 : wreg;
            m_valid = valid;
            m_rw    = valid && regwrite && dest != 5'd0;
            m_mis   = valid && memtoreg && !jal && ref_mis(off, int'(size));
            m_idx   = dest;
            m_data  = jal ? pc4 : (memtoreg ? ref_load(mem, off, int'(size), uns) : alu);
            m_chk   = valid;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".rw"},    32'(rw_o),  32'(m_rw));
        check({tag, ".valid"}, 32'(wbv_o), 32'(m_valid));
        check({tag, ".mis"},   32'(mis_o), 32'(m_mis));
        if (m_chk) begin
            check({tag, ".idx"},  32'(idx_o), 32'(m_idx));
            check({tag, ".data"}, data_o,     m_data);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic j,
                         input logic [1:0] sz, input logic u, input logic [4:0] wr,
                         input logic [31:0] a, input logic [31:0] m, input logic [31:0] p);
        valid = v; regwrite = rw; memtoreg = m2r; jal = j; size = sz; uns = u;
        wreg = wr; alu = a; mem = m; pc4 = p;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_rw = 1'b0; m_mis = 1'b0; m_chk = 1'b1; m_idx = 5'd0; m_data = 32'd0;
        // Reset with every input active
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0100);
        tick("rst0");
        tick("rst1");
        check("rst.data", data_o, 32'd0);
        check("rst.idx", 32'(idx_o), 32'd0);
        rst_n = 1'b1;

        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd8, 32'h0000_1234, 32'h0, 32'h0);
        tick("alu");
        check("alu.data_const", data_o, 32'h0000_1234);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 5'd3, 32'h0000_0003, 32'h80FF_7F01, 32'h0);
        tick("lb3");
        check("lb3.const", data_o, 32'hFFFF_FF80);
        uns = 1'b1;
        tick("lbu3");
        check("lbu3.const", data_o, 32'h0000_0080);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 32'h0000_0002, 32'h80FF_7F01, 32'h0);
        tick("lh2");
        check("lh2.const", data_o, 32'hFFFF_80FF);
        alu = 32'h0000_0001;
        tick("lh1");
        check("lh1.mis_const", 32'(mis_o), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd6, 32'h0000_0002, 32'hCAFE_F00D, 32'h0);
        tick("lw2");

        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 5'd5, 32'h0000_0001, 32'h1111_2222, 32'h0040_0010);
        tick("jal");
        check("jal.idx_const", 32'(idx_o), 32'd31);
        check("jal.data_const", data_o, 32'h0040_0010);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0000_0055, 32'h0, 32'h0);
        tick("r0");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd7, 32'h0000_0066, 32'h0, 32'h0);
        tick("bubble");

        // Stall while inputs keep changing
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd12, 32'h0000_ABCD, 32'h0, 32'h0);
        tick("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'(i + 20), $urandom, $urandom, $urandom);
            tick("stall");
            check("stall.data_const", data_o, 32'h0000_ABCD);
        end
        flush = 1'b1;
        tick("stall_flush");
        stall = 1'b0; flush = 1'b0;

        // Reset in the middle of a valid write
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd17, 32'h0000_7777, 32'h0, 32'h0);
        tick("pre_rst");
        rst_n = 1'b0;
        tick("mid_rst");
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0),
                  2'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
